// File: rtl/edge_detector_stream_if.sv
// Display-memory bus used by edge_detector_stream.
//   master: the edge detector (drives request, address, direction, write data)
//   slave : the memory (drives acknowledge and read data)
// Handshake: de_req, de_addr, de_rnw, de_nbyte and de_w_data stay stable from the
// cycle de_req rises through the cycle de_ack=1. The transfer completes on the
// clock edge where de_req=1 and de_ack=1. de_ack while de_req=0 means nothing.
// de_r_data is valid only in the de_ack cycle of a read.
interface edge_detector_stream_if;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data;

  modport master (
    output de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    input  de_ack, de_r_data
  );

  modport slave (
    input  de_req, de_addr, de_nbyte, de_rnw, de_w_data,
    output de_ack, de_r_data
  );
endinterface

// File: rtl/edge_detector_stream.sv
// Streaming edge detector. One accepted req runs a pass over a packed 8-bit
// greyscale frame (4 pixels per word, lane0 = leftmost), writing a gradient or
// binary edge image, one output word per input word.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   req        start request (level); ignored while busy
//   ack        one-cycle pulse when a request is accepted
//   busy       high from accept until the last write is acknowledged
//   thresh     edge threshold, captured on accept
//   mode       0 = binary 00/FF, 1 = saturated magnitude; captured on accept
//   de         display-memory bus (master side)
//   state_dbg  current FSM state encoding
module edge_detector_stream #(
  parameter int          IMG_W    = 640,
  parameter int          IMG_H    = 480,
  parameter logic [17:0] SRC_BASE = 18'h00000,
  parameter logic [17:0] DST_BASE = 18'h20000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  output logic                   ack,
  output logic                   busy,
  input  logic [7:0]             thresh,
  input  logic                   mode,
  edge_detector_stream_if.master de,
  output logic [2:0]             state_dbg
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 4);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CALC = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        ack_n, busy_n;
  logic        de_req_q, de_req_n, de_rnw_q, de_rnw_n;
  logic [17:0] de_addr_q, de_addr_n, src_q, src_n, dst_q, dst_n;
  logic [31:0] de_w_data_q, de_w_data_n, rd_word_q, rd_word_n, wr_word_q, wr_word_n;
  logic [XW-1:0] x_q, x_n;
  logic [YW-1:0] y_q, y_n;
  logic [1:0]  lane_q, lane_n;
  logic [7:0]  thr_q, thr_n, left_q, left_n;
  logic        mode_q, mode_n;

  // Previous row of pixels; never cleared because row 0 ignores it.
  logic [7:0]  lb [IMG_W];
  logic        lb_we;

  logic [XW-1:0] col;
  logic [7:0]  pix, above, leftp, dh, dv, out_px;
  logic [8:0]  grad;

  assign de.de_req    = de_req_q;
  assign de.de_rnw    = de_rnw_q;
  assign de.de_addr   = de_addr_q;
  assign de.de_w_data = de_w_data_q;
  assign de.de_nbyte  = 4'b0000;
  assign state_dbg    = state;

  // Per-lane gradient datapath, used in CALC.
  always_comb begin
    col    = x_q + XW'(lane_q);
    pix    = rd_word_q[8*lane_q +: 8];
    above  = (y_q == '0) ? pix : lb[col];
    leftp  = (col == '0) ? pix : left_q;
    dh     = (pix >= leftp) ? (pix - leftp) : (leftp - pix);
    dv     = (pix >= above) ? (pix - above) : (above - pix);
    grad   = {1'b0, dh} + {1'b0, dv};
    if (mode_q) out_px = grad[8] ? 8'hFF : grad[7:0];
    else        out_px = (grad >= {1'b0, thr_q}) ? 8'hFF : 8'h00;
  end

  always_comb begin
    state_n     = state;
    ack_n       = 1'b0;
    busy_n      = busy;
    de_req_n    = de_req_q;
    de_rnw_n    = de_rnw_q;
    de_addr_n   = de_addr_q;
    de_w_data_n = de_w_data_q;
    src_n       = src_q;
    dst_n       = dst_q;
    rd_word_n   = rd_word_q;
    wr_word_n   = wr_word_q;
    x_n         = x_q;
    y_n         = y_q;
    lane_n      = lane_q;
    thr_n       = thr_q;
    mode_n      = mode_q;
    left_n      = left_q;
    lb_we       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          ack_n   = 1'b1;
          busy_n  = 1'b1;
          thr_n   = thresh;
          mode_n  = mode;
          src_n   = SRC_BASE;
          dst_n   = DST_BASE;
          x_n     = '0;
          y_n     = '0;
          state_n = RD;
        end
      end
      RD: begin
        // First cycle in RD raises the request; de_req is low on entry,
        // which guarantees the idle cycle between bus transfers.
        if (!de_req_q) begin
          de_req_n  = 1'b1;
          de_rnw_n  = 1'b1;
          de_addr_n = src_q;
        end else if (de.de_ack) begin
          de_req_n  = 1'b0;
          rd_word_n = de.de_r_data;
          lane_n    = 2'd0;
          state_n   = CALC;
        end
      end
      CALC: begin
        lb_we  = 1'b1;
        left_n = pix;
        wr_word_n[8*lane_q +: 8] = out_px;
        lane_n = lane_q + 2'd1;
        if (lane_q == 2'd3) state_n = WR;
      end
      WR: begin
        if (!de_req_q) begin
          de_req_n    = 1'b1;
          de_rnw_n    = 1'b0;
          de_addr_n   = dst_q;
          de_w_data_n = wr_word_q;
        end else if (de.de_ack) begin
          de_req_n = 1'b0;
          src_n    = src_q + 18'd1;
          dst_n    = dst_q + 18'd1;
          if (x_q == X_LAST) begin
            x_n = '0;
            if (y_q == Y_LAST) begin
              y_n     = '0;
              busy_n  = 1'b0;
              state_n = FIN;
            end else begin
              y_n     = y_q + YW'(1);
              state_n = RD;
            end
          end else begin
            x_n     = x_q + XW'(4);
            state_n = RD;
          end
        end
      end
      FIN: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ack         <= 1'b0;
      busy        <= 1'b0;
      de_req_q    <= 1'b0;
      de_rnw_q    <= 1'b0;
      de_addr_q   <= '0;
      de_w_data_q <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rd_word_q   <= '0;
      wr_word_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lane_q      <= '0;
      thr_q       <= '0;
      mode_q      <= 1'b0;
      left_q      <= '0;
    end else begin
      state       <= state_n;
      ack         <= ack_n;
      busy        <= busy_n;
      de_req_q    <= de_req_n;
      de_rnw_q    <= de_rnw_n;
      de_addr_q   <= de_addr_n;
      de_w_data_q <= de_w_data_n;
      src_q       <= src_n;
      dst_q       <= dst_n;
      rd_word_q   <= rd_word_n;
      wr_word_q   <= wr_word_n;
      x_q         <= x_n;
      y_q         <= y_n;
      lane_q      <= lane_n;
      thr_q       <= thr_n;
      mode_q      <= mode_n;
      left_q      <= left_n;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lb[col] <= pix;
  end
endmodule
